rv32m_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer and datapath for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/rv32m_pkg.sv | 43 ++++
 rtl/rv32m_sign_fix.sv | 12 +
 rtl/rv32m_muldiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_rv32m_muldiv_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M multi-cycle unit: funct3 encodings, FSM states and decode helpers.
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // Upper product half is returned for MULH, MULHSU and MULHU.
  function automatic logic f3_is_mulhi(input logic [2:0] f3);
    return ~f3[2] & (f3[1:0] != 2'b00);
  endfunction

  function automatic logic f3_rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/rv32m_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction at operand entry, sign restore at result exit.
module rv32m_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/rv32m_muldiv_seq.sv
// RV32M sequencer: radix-2 shift-add multiply / restoring divide, 32 CALC + 1 FIX cycles per op.
// Stalls the pipeline until done; div-by-zero and signed overflow may short-cut straight to DONE.
module rv32m_muldiv_seq #(
  parameter int XLEN     = rv32m_pkg::XLEN,
  parameter bit FAST_DIV = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import rv32m_pkg::*;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [CW-1:0]     count_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // hi/lo hold {product_hi, product_lo} for multiply and {remainder, quotient} for divide.
  logic [XLEN-1:0]   hi_q, lo_q, mcand_q;
  logic [XLEN-1:0]   hi_d, lo_d;
  logic [2:0]        op_q;
  logic              neg_q, s1_q, div0_q;

  logic              s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              idle_like, accept;
  logic              div0, ovf, fast;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;

  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   fix_res;

  assign s1 = f3_rs1_signed(funct3) & op1[XLEN-1];
  assign s2 = f3_rs2_signed(funct3) & op2[XLEN-1];

  rv32m_sign_fix #(.W(XLEN)) u_abs1 (.val_i(op1), .neg_i(s1), .val_o(mag1));
  rv32m_sign_fix #(.W(XLEN)) u_abs2 (.val_i(op2), .neg_i(s2), .val_o(mag2));

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = start & idle_like & ~flush;

  assign div0 = (op2 == '0);
  assign ovf  = ~funct3[0] & (op1 == MIN_NEG) & (op2 == ALL_ONES);
  assign fast = FAST_DIV & f3_is_div(funct3) & (div0 | ovf);

  always_comb begin
    fast_res = '0;
    if (div0) begin
      fast_res = f3_is_rem(funct3) ? op1 : ALL_ONES;
    end else begin
      fast_res = f3_is_rem(funct3) ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, mcand_q});
    // Remainder after a successful trial is below the divisor, so XLEN bits suffice.
    div_diff = div_sh[XLEN-1:0] - mcand_q;
    hi_d     = mul_sum[XLEN:1];
    lo_d     = {mul_sum[0], lo_q[XLEN-1:1]};
    if (f3_is_div(op_q)) begin
      hi_d = div_ge ? div_diff : div_sh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end
  end

  always_comb begin
    fix_in  = {hi_q, lo_q};
    fix_neg = neg_q;
    if (f3_is_rem(op_q)) begin
      fix_in  = {{XLEN{1'b0}}, hi_q};
      fix_neg = s1_q;
    end else if (f3_is_div(op_q)) begin
      fix_in  = {{XLEN{1'b0}}, lo_q};
    end
  end

  rv32m_sign_fix #(.W(2*XLEN)) u_fix (.val_i(fix_in), .neg_i(fix_neg), .val_o(fix_out));

  always_comb begin
    fix_res = fix_out[XLEN-1:0];
    if (f3_is_mulhi(op_q)) begin
      fix_res = fix_out[2*XLEN-1:XLEN];
    end else if (div0_q && f3_is_div(op_q) && !f3_is_rem(op_q)) begin
      // A zero divisor yields an all-ones quotient magnitude; the signed fix-up must not touch it.
      fix_res = ALL_ONES;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        count_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start && fast) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= fast_res;
            end else if (start) begin
              state_q <= ST_CALC;
              count_q <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_CALC: begin
            count_q <= count_q + CW'(1);
            if (count_q == CW'(XLEN-1)) begin
              state_q <= ST_FIX;
            end
          end
          ST_FIX: begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= fix_res;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      op_q    <= F3_MUL;
      neg_q   <= 1'b0;
      s1_q    <= 1'b0;
      div0_q  <= 1'b0;
    end else if (accept) begin
      hi_q    <= '0;
      lo_q    <= f3_is_div(funct3) ? mag1 : mag2;
      mcand_q <= f3_is_div(funct3) ? mag2 : mag1;
      op_q    <= funct3;
      neg_q   <= s1 ^ s2;
      s1_q    <= s1;
      div0_q  <= div0;
    end else if (state_q == ST_CALC) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign stall  = busy | (start & idle_like);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_seq.sv
// Directed bench for rv32m_muldiv_seq: results, latency, stall window, fast div cases, flush, async reset, back-to-back.
module tb_rv32m_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic        flush;
  logic        busy, stall, done;
  logic [31:0] result;

  int vec  = 0;
  int miss = 0;

  always #5 CLK = ~CLK;

  rv32m_muldiv_seq #(.XLEN(32), .FAST_DIV(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Call just after a rising edge with the unit idle; returns at the falling edge of the done cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stl, output bit ok);
    funct3 = f3; op1 = a; op2 = b; start = 1'b1;
    lat = 0; stl = 0; ok = 1'b0; res = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (stall) stl++;
      if (done) begin
        res = result;
        ok  = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
      start = 1'b0;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op1 = '0; op2 = '0;
    repeat (2) @(negedge CLK);
    vec++; if (busy !== 1'b0)  begin miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL reset_stall: got %b expected 0", stall); end
    vec++; if (done !== 1'b0)  begin miss++; $display("FAIL reset_done: got %b expected 0", done); end
    vec++; if (result !== 32'h0) begin miss++; $display("FAIL reset_result: got %h expected 0", result); end
    next_cycle();
    RESET = 1'b0;
    next_cycle();
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, stl; bit ok;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, stl, ok);
    vec++; if (!ok || r !== 32'hFFFF_FFEB) begin miss++; $display("FAIL mul_result: got %h (done=%0d) expected ffffffeb", r, ok); end
    vec++; if (lat !== 34) begin miss++; $display("FAIL mul_latency: got %0d expected 34", lat); end
    vec++; if (stl !== 34) begin miss++; $display("FAIL mul_stall_cycles: got %0d expected 34", stl); end
    next_cycle();
    @(negedge CLK);
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
    vec++; if (result !== 32'hFFFF_FFEB) begin miss++; $display("FAIL mul_result_hold: got %h expected ffffffeb", result); end
    next_cycle();
  endtask

  task automatic test_mulh();
    logic [2:0]  f3s [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    logic [31:0] ex  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] r; int lat, stl; bit ok;
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], as[i], bs[i], r, lat, stl, ok);
      vec++; if (!ok || r !== ex[i]) begin miss++; $display("FAIL mulh_result[%0d]: got %h expected %h", i, r, ex[i]); end
      vec++; if (lat !== 34) begin miss++; $display("FAIL mulh_latency[%0d]: got %0d expected 34", i, lat); end
      next_cycle();
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b111};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd0, 32'h8000_0000};
    logic [31:0] r; int lat, stl; bit ok;
    for (int i = 0; i < 6; i++) begin
      run_op(f3s[i], as[i], bs[i], r, lat, stl, ok);
      vec++; if (!ok || r !== ex[i]) begin miss++; $display("FAIL div_result[%0d]: got %h expected %h", i, r, ex[i]); end
      vec++; if (lat !== 34) begin miss++; $display("FAIL div_latency[%0d]: got %0d expected 34", i, lat); end
      next_cycle();
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f3s [7] = '{3'b100, 3'b110, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [7] = '{32'd5, 32'd5, 32'hFFFF_FFF7, 32'd5, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [7] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'd0};
    logic [31:0] r; int lat, stl; bit ok;
    for (int i = 0; i < 7; i++) begin
      run_op(f3s[i], as[i], bs[i], r, lat, stl, ok);
      vec++; if (!ok || r !== ex[i]) begin miss++; $display("FAIL divspec_result[%0d]: got %h expected %h", i, r, ex[i]); end
      vec++; if (lat !== 1) begin miss++; $display("FAIL divspec_latency[%0d]: got %0d expected 1", i, lat); end
      vec++; if (stl !== 1) begin miss++; $display("FAIL divspec_stall[%0d]: got %0d expected 1", i, stl); end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0; int d1 = -1; int d2 = -1;
    logic [31:0] r1 = '0; logic [31:0] r2 = '0;
    funct3 = 3'b100; op1 = 32'hFFFF_FFF9; op2 = 32'd2; start = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge CLK);
      if (done) begin
        dones++;
        if (dones == 1) begin
          d1 = cyc; r1 = result;
          funct3 = 3'b111; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        end else if (dones == 2) begin
          d2 = cyc; r2 = result;
        end
      end
      @(posedge CLK);
      #1;
      start = 1'b0;
    end
    vec++; if (dones !== 2) begin miss++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
    vec++; if (d1 !== 34) begin miss++; $display("FAIL b2b_first_latency: got %0d expected 34", d1); end
    vec++; if (d2 - d1 !== 34) begin miss++; $display("FAIL b2b_second_latency: got %0d expected 34", d2 - d1); end
    vec++; if (r1 !== 32'hFFFF_FFFD) begin miss++; $display("FAIL b2b_first_result: got %h expected fffffffd", r1); end
    vec++; if (r2 !== 32'd2) begin miss++; $display("FAIL b2b_second_result: got %h expected 00000002", r2); end
  endtask

  task automatic test_flush();
    int dones = 0;
    logic [31:0] r; int lat, stl; bit ok;
    funct3 = 3'b000; op1 = 32'd5; op2 = 32'd6; start = 1'b1;
    repeat (11) begin
      @(posedge CLK);
      #1;
      start = 1'b0;
    end
    @(negedge CLK);
    vec++; if (busy !== 1'b1) begin miss++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    @(negedge CLK);
    vec++; if (busy !== 1'b0)  begin miss++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL flush_stall_after: got %b expected 0", stall); end
    repeat (40) begin
      @(negedge CLK);
      if (done) dones++;
    end
    vec++; if (dones !== 0) begin miss++; $display("FAIL flush_no_done: got %0d expected 0", dones); end
    vec++; if (result !== 32'd2) begin miss++; $display("FAIL flush_result_kept: got %h expected 00000002", result); end
    next_cycle();
    run_op(3'b101, 32'd100, 32'd7, r, lat, stl, ok);
    vec++; if (!ok || r !== 32'd14) begin miss++; $display("FAIL flush_recover: got %h expected 0000000e", r); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    int dones = 0;
    funct3 = 3'b000; op1 = 32'd7; op2 = 32'd3; start = 1'b1;
    repeat (6) begin
      @(posedge CLK);
      #1;
      start = 1'b0;
    end
    vec++; if (busy !== 1'b1) begin miss++; $display("FAIL arst_busy_before: got %b expected 1", busy); end
    vec++; if (result !== 32'd14) begin miss++; $display("FAIL arst_result_before: got %h expected 0000000e", result); end
    #2;
    RESET = 1'b1;
    #1;
    vec++; if (busy !== 1'b0)    begin miss++; $display("FAIL arst_busy: got %b expected 0", busy); end
    vec++; if (stall !== 1'b0)   begin miss++; $display("FAIL arst_stall: got %b expected 0", stall); end
    vec++; if (done !== 1'b0)    begin miss++; $display("FAIL arst_done: got %b expected 0", done); end
    vec++; if (result !== 32'h0) begin miss++; $display("FAIL arst_result: got %h expected 0", result); end
    next_cycle();
    RESET = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (done) dones++;
    end
    vec++; if (dones !== 0) begin miss++; $display("FAIL arst_no_done: got %0d expected 0", dones); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
